// File: rtl/sc_psr_branch_ctrl_pkg.sv
// Shared definitions for the PSR flag-path micro-sequencer.
//   - state_t   : FSM state encoding
//   - COND_*    : SPARC Bicc condition codes (bit 3 inverts bits 2..0)
//   - PSR_*_BIT : positions of N/Z/V/C inside the 32-bit PSR word
//   - cmd_t     : command fields captured when a request is accepted
package sc_psr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRPSR = 3'd3,
    ST_EVAL  = 3'd4
  } state_t;

  localparam logic [3:0] COND_NEVER = 4'd0;
  localparam logic [3:0] COND_E     = 4'd1;
  localparam logic [3:0] COND_LE    = 4'd2;
  localparam logic [3:0] COND_L     = 4'd3;
  localparam logic [3:0] COND_LEU   = 4'd4;
  localparam logic [3:0] COND_CS    = 4'd5;
  localparam logic [3:0] COND_NEG   = 4'd6;
  localparam logic [3:0] COND_VS    = 4'd7;
  localparam logic [3:0] COND_ALWAYS = 4'd8;
  localparam logic [3:0] COND_NE    = 4'd9;
  localparam logic [3:0] COND_G     = 4'd10;
  localparam logic [3:0] COND_GE    = 4'd11;
  localparam logic [3:0] COND_GU    = 4'd12;
  localparam logic [3:0] COND_CC    = 4'd13;
  localparam logic [3:0] COND_POS   = 4'd14;
  localparam logic [3:0] COND_VC    = 4'd15;

  localparam int PSR_N_BIT = 23;
  localparam int PSR_Z_BIT = 22;
  localparam int PSR_V_BIT = 21;
  localparam int PSR_C_BIT = 20;

  typedef struct packed {
    logic       set_cc;
    logic       is_branch;
    logic [3:0] cond;
  } cmd_t;

  // Extracts {N,Z,V,C} from a full PSR word, for callers that hold the
  // register value rather than the individual flag wires.
  function automatic logic [3:0] psr_flags(input logic [31:0] psr);
    return {psr[PSR_N_BIT], psr[PSR_Z_BIT], psr[PSR_V_BIT], psr[PSR_C_BIT]};
  endfunction

endpackage

// File: rtl/sc_psr_branch_ctrl_if.sv
// Request/flag/strobe bundle between the microcode front end, the PSR
// register and the flag-path sequencer.
//   master : front end / PSR side (drives request fields, flush, flags)
//   slave  : sequencer (drives ready, operand latch, PSR write, done, taken)
interface sc_psr_branch_ctrl_if;
  logic       SC_PSRCtrl_Req_InHigh;
  logic       SC_PSRCtrl_Ready_OutHigh;
  logic       SC_PSRCtrl_SetCC_InHigh;
  logic       SC_PSRCtrl_IsBranch_InHigh;
  logic [3:0] SC_PSRCtrl_Cond_In;
  logic       SC_PSRCtrl_Flush_InHigh;
  logic       SC_PSRCtrl_N_InHigh;
  logic       SC_PSRCtrl_Z_InHigh;
  logic       SC_PSRCtrl_V_InHigh;
  logic       SC_PSRCtrl_C_InHigh;
  logic       SC_PSRCtrl_OpLatch_OutHigh;
  logic       SC_PSRCtrl_PSRWrite_OutHigh;
  logic       SC_PSRCtrl_Done_OutHigh;
  logic       SC_PSRCtrl_Taken_OutHigh;

  modport master (
    output SC_PSRCtrl_Req_InHigh, SC_PSRCtrl_SetCC_InHigh, SC_PSRCtrl_IsBranch_InHigh,
           SC_PSRCtrl_Cond_In, SC_PSRCtrl_Flush_InHigh,
           SC_PSRCtrl_N_InHigh, SC_PSRCtrl_Z_InHigh, SC_PSRCtrl_V_InHigh, SC_PSRCtrl_C_InHigh,
    input  SC_PSRCtrl_Ready_OutHigh, SC_PSRCtrl_OpLatch_OutHigh, SC_PSRCtrl_PSRWrite_OutHigh,
           SC_PSRCtrl_Done_OutHigh, SC_PSRCtrl_Taken_OutHigh
  );

  modport slave (
    input  SC_PSRCtrl_Req_InHigh, SC_PSRCtrl_SetCC_InHigh, SC_PSRCtrl_IsBranch_InHigh,
           SC_PSRCtrl_Cond_In, SC_PSRCtrl_Flush_InHigh,
           SC_PSRCtrl_N_InHigh, SC_PSRCtrl_Z_InHigh, SC_PSRCtrl_V_InHigh, SC_PSRCtrl_C_InHigh,
    output SC_PSRCtrl_Ready_OutHigh, SC_PSRCtrl_OpLatch_OutHigh, SC_PSRCtrl_PSRWrite_OutHigh,
           SC_PSRCtrl_Done_OutHigh, SC_PSRCtrl_Taken_OutHigh
  );
endinterface

// File: rtl/sc_psr_branch_ctrl_cond_eval.sv
// Purely combinational SPARC Bicc condition evaluator.
//   cond   : 4-bit branch condition code
//   n,z,v,c: PSR flags
//   result : condition holds
module sc_psr_cond_eval
  import sc_psr_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  input  logic       c,
  output logic       result
);

  logic base;

  // Codes 8..15 are the complements of 0..7, so only the low three bits
  // select a test and bit 3 flips it.
  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      COND_NEVER[2:0]: base = 1'b0;
      COND_E[2:0]:     base = z;
      COND_LE[2:0]:    base = z | (n ^ v);
      COND_L[2:0]:     base = n ^ v;
      COND_LEU[2:0]:   base = c | z;
      COND_CS[2:0]:    base = c;
      COND_NEG[2:0]:   base = n;
      COND_VS[2:0]:    base = v;
      default:         base = 1'b0;
    endcase
    result = base ^ cond[3];
  end

endmodule

// File: rtl/sc_psr_branch_ctrl.sv
// Flag-path micro-sequencer: accepts one ALU/branch micro-op, pulses the
// operand latch, waits ALU_LAT settle cycles, optionally pulses the PSR
// write strobe, then reports branch taken/not-taken with a Done pulse.
//   SC_PSRCtrl_CLOCK_50    : clock, all state on posedge
//   SC_PSRCtrl_Reset_InLow : asynchronous active-low reset
//   bus (slave)            : request fields, flush, PSR flags in;
//                            ready, op latch, PSR write, done, taken out
module sc_psr_branch_ctrl
  import sc_psr_ctrl_pkg::*;
#(
  parameter int ALU_LAT   = 1,
  parameter int CNT_WIDTH = 4
) (
  input  logic              SC_PSRCtrl_CLOCK_50,
  input  logic              SC_PSRCtrl_Reset_InLow,
  sc_psr_branch_ctrl_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(ALU_LAT - 1);

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  cmd_t                 cmd_reg, cmd_next;

  logic ready, op_latch, psr_write, done, taken;
  logic cond_true;
  logic flush;

  assign flush = bus.SC_PSRCtrl_Flush_InHigh;

  sc_psr_cond_eval u_cond_eval (
    .cond   (cmd_reg.cond),
    .n      (bus.SC_PSRCtrl_N_InHigh),
    .z      (bus.SC_PSRCtrl_Z_InHigh),
    .v      (bus.SC_PSRCtrl_V_InHigh),
    .c      (bus.SC_PSRCtrl_C_InHigh),
    .result (cond_true)
  );

  always_ff @(posedge SC_PSRCtrl_CLOCK_50 or negedge SC_PSRCtrl_Reset_InLow) begin
    if (!SC_PSRCtrl_Reset_InLow) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      cmd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cmd_reg   <= cmd_next;
    end
  end

  // Flush is honoured in every busy state and suppresses that state's
  // strobe in the same cycle, so an aborted op leaves no side effects.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cmd_next   = cmd_reg;
    ready      = 1'b0;
    op_latch   = 1'b0;
    psr_write  = 1'b0;
    done       = 1'b0;
    taken      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.SC_PSRCtrl_Req_InHigh) begin
          cmd_next.set_cc    = bus.SC_PSRCtrl_SetCC_InHigh;
          cmd_next.is_branch = bus.SC_PSRCtrl_IsBranch_InHigh;
          cmd_next.cond      = bus.SC_PSRCtrl_Cond_In;
          state_next         = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          op_latch   = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == '0) begin
          state_next = cmd_reg.set_cc ? ST_WRPSR : ST_EVAL;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_WRPSR: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          psr_write  = 1'b1;
          state_next = ST_EVAL;
        end
      end
      ST_EVAL: begin
        state_next = ST_IDLE;
        if (!flush) begin
          done  = 1'b1;
          taken = cmd_reg.is_branch & cond_true;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.SC_PSRCtrl_Ready_OutHigh    = ready;
  assign bus.SC_PSRCtrl_OpLatch_OutHigh  = op_latch;
  assign bus.SC_PSRCtrl_PSRWrite_OutHigh = psr_write;
  assign bus.SC_PSRCtrl_Done_OutHigh     = done;
  assign bus.SC_PSRCtrl_Taken_OutHigh    = taken;

endmodule

// File: tb/tb_sc_psr_branch_ctrl.sv
// Scoreboard bench: the stimulus process pushes expected output events
// (operand latch, PSR write, done+taken) with their absolute cycle; a
// separate monitor pops and compares whenever the DUT asserts a strobe.
module tb_sc_psr_branch_ctrl;
  localparam int LAT = 3;
  localparam int EV_OPL = 0, EV_PSRW = 1, EV_DONE = 2;

  typedef struct {
    int kind;
    int cyc;
    bit taken;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sc_psr_branch_ctrl_if bus ();
  sc_psr_branch_ctrl_if bus1 ();

  sc_psr_branch_ctrl #(.ALU_LAT(LAT), .CNT_WIDTH(4)) u_dut (
    .SC_PSRCtrl_CLOCK_50    (clk),
    .SC_PSRCtrl_Reset_InLow (rst_n),
    .bus                    (bus)
  );

  sc_psr_branch_ctrl #(.ALU_LAT(1), .CNT_WIDTH(4)) u_dut1 (
    .SC_PSRCtrl_CLOCK_50    (clk),
    .SC_PSRCtrl_Reset_InLow (rst_n),
    .bus                    (bus1)
  );

  ev_t exp_q[$];
  int  win_start = 0, win_end = 0;   // model busy window [start, end)
  int  n_cmp = 0, n_bad = 0;
  bit  mon_en = 1'b0;
  int  op_no = 0;

  // Branch table written out code by code.
  function automatic bit bicc_ref(input bit [3:0] cond, input bit [3:0] fl);
    bit n, z, v, c;
    {n, z, v, c} = fl;
    case (cond)
      4'd0:  return 1'b0;
      4'd1:  return z;
      4'd2:  return z | (n ^ v);
      4'd3:  return n ^ v;
      4'd4:  return c | z;
      4'd5:  return c;
      4'd6:  return n;
      4'd7:  return v;
      4'd8:  return 1'b1;
      4'd9:  return !z;
      4'd10: return !(z | (n ^ v));
      4'd11: return !(n ^ v);
      4'd12: return !(c | z);
      4'd13: return !c;
      4'd14: return !n;
      default: return !v;
    endcase
  endfunction

  task automatic check1(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_flags(input bit [3:0] fl);
    {bus.SC_PSRCtrl_N_InHigh, bus.SC_PSRCtrl_Z_InHigh,
     bus.SC_PSRCtrl_V_InHigh, bus.SC_PSRCtrl_C_InHigh} = fl;
  endtask

  task automatic garbage_fields();
    bus.SC_PSRCtrl_SetCC_InHigh    = 1'($urandom);
    bus.SC_PSRCtrl_IsBranch_InHigh = 1'($urandom);
    bus.SC_PSRCtrl_Cond_In         = 4'($urandom);
  endtask

  // Monitor-side event match: pops the front entry when it matches.
  task automatic chk_event(input int kind, input string name, input bit taken_act);
    n_cmp++;
    if (exp_q.size() > 0 && exp_q[0].kind == kind && exp_q[0].cyc == cyc) begin
      if (kind == EV_DONE && taken_act != exp_q[0].taken) begin
        n_bad++;
        $display("FAIL taken at cycle %0d: got %0d expected %0d", cyc, taken_act, exp_q[0].taken);
      end
      void'(exp_q.pop_front());
    end else begin
      n_bad++;
      $display("FAIL unexpected %s at cycle %0d: got 1 expected 0", name, cyc);
    end
  endtask

  initial begin : monitor
    bit exp_rdy;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        exp_rdy = !(cyc >= win_start && cyc < win_end);
        check1($sformatf("ready@%0d", cyc), int'(bus.SC_PSRCtrl_Ready_OutHigh), int'(exp_rdy));
        if (!bus.SC_PSRCtrl_Done_OutHigh)
          check1($sformatf("taken_without_done@%0d", cyc), int'(bus.SC_PSRCtrl_Taken_OutHigh), 0);
        if (bus.SC_PSRCtrl_OpLatch_OutHigh)  chk_event(EV_OPL, "oplatch", 1'b0);
        if (bus.SC_PSRCtrl_PSRWrite_OutHigh) chk_event(EV_PSRW, "psrwrite", 1'b0);
        if (bus.SC_PSRCtrl_Done_OutHigh)     chk_event(EV_DONE, "done", bus.SC_PSRCtrl_Taken_OutHigh);
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missing event kind %0d due cycle %0d: got 0 expected 1", exp_q[0].kind, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Issues one op on the main DUT. Called at posedge+1 of an idle cycle;
  // returns at posedge+1 of the first idle cycle after the op.
  // flush_rel: 0 = none, r = flush in cycle r after the accept edge.
  task automatic run_op(input bit setcc, input bit isbr, input bit [3:0] cond,
                        input bit [3:0] fl, input int flush_rel, input bit flush_req,
                        input bit keep_req);
    int a, wr, dn, f, last;
    bit exp_t;
    a  = cyc + 1;
    wr = a + LAT + 1;
    dn = a + LAT + 1 + int'(setcc);
    f  = (flush_rel > 0) ? a + flush_rel - 1 : dn + 1000;
    exp_t = isbr & bicc_ref(cond, fl);
    if (a < f) exp_q.push_back('{EV_OPL, a, 1'b0});
    if (setcc && wr < f) exp_q.push_back('{EV_PSRW, wr, 1'b0});
    if (dn < f) exp_q.push_back('{EV_DONE, dn, exp_t});
    win_start = a;
    win_end   = (flush_rel > 0) ? f + 1 : dn + 1;
    last      = (flush_rel > 0) ? f : dn;
    bus.SC_PSRCtrl_Req_InHigh      = 1'b1;
    bus.SC_PSRCtrl_SetCC_InHigh    = setcc;
    bus.SC_PSRCtrl_IsBranch_InHigh = isbr;
    bus.SC_PSRCtrl_Cond_In         = cond;
    bus.SC_PSRCtrl_Flush_InHigh    = flush_req;
    set_flags(setcc ? 4'($urandom) : fl);
    $display("op %0d: accept@%0d setcc=%0d br=%0d cond=%0d flags=%h flush_rel=%0d exp_taken=%0d",
             op_no, a, setcc, isbr, cond, fl, flush_rel, exp_t);
    op_no++;
    for (int c = a; c <= last; c++) begin
      @(posedge clk); #1;
      bus.SC_PSRCtrl_Req_InHigh   = keep_req;
      garbage_fields();
      bus.SC_PSRCtrl_Flush_InHigh = (c == f);
      if (setcc) begin
        if (c < wr) set_flags(4'($urandom));
        else if (c == wr) set_flags(fl);
      end
    end
    @(posedge clk); #1;
    bus.SC_PSRCtrl_Flush_InHigh = 1'b0;
    bus.SC_PSRCtrl_Req_InHigh   = keep_req;
    garbage_fields();
  endtask

  // Directed check on the ALU_LAT=1 instance, relative cycle numbers.
  task automatic dut1_op(input bit setcc, input bit [3:0] cond, input bit [3:0] fl);
    int opl_r = -1, psw_r = -1, dn_r = -1, tk = -1;
    bus1.SC_PSRCtrl_Req_InHigh      = 1'b1;
    bus1.SC_PSRCtrl_SetCC_InHigh    = setcc;
    bus1.SC_PSRCtrl_IsBranch_InHigh = 1'b1;
    bus1.SC_PSRCtrl_Cond_In         = cond;
    {bus1.SC_PSRCtrl_N_InHigh, bus1.SC_PSRCtrl_Z_InHigh,
     bus1.SC_PSRCtrl_V_InHigh, bus1.SC_PSRCtrl_C_InHigh} = fl;
    @(posedge clk); #1;
    bus1.SC_PSRCtrl_Req_InHigh   = 1'b0;
    bus1.SC_PSRCtrl_SetCC_InHigh = ~setcc;
    bus1.SC_PSRCtrl_Cond_In      = ~cond;
    for (int r = 1; r <= 7; r++) begin
      @(negedge clk);
      if (bus1.SC_PSRCtrl_OpLatch_OutHigh && opl_r < 0) opl_r = r;
      if (bus1.SC_PSRCtrl_PSRWrite_OutHigh && psw_r < 0) psw_r = r;
      if (bus1.SC_PSRCtrl_Done_OutHigh && dn_r < 0) begin
        dn_r = r;
        tk = int'(bus1.SC_PSRCtrl_Taken_OutHigh);
      end
    end
    $display("lat1 op: setcc=%0d cond=%0d oplatch@%0d psrwrite@%0d done@%0d taken=%0d",
             setcc, cond, opl_r, psw_r, dn_r, tk);
    check1("lat1_oplatch_cycle", opl_r, 1);
    check1("lat1_psrwrite_cycle", psw_r, setcc ? 3 : -1);
    check1("lat1_done_cycle", dn_r, 3 + int'(setcc));
    check1("lat1_taken", tk, int'(bicc_ref(cond, fl)));
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.SC_PSRCtrl_Req_InHigh = 1'b0;
    bus.SC_PSRCtrl_Flush_InHigh = 1'b0;
    garbage_fields();
    set_flags(4'h0);
    bus1.SC_PSRCtrl_Req_InHigh = 1'b0;
    bus1.SC_PSRCtrl_Flush_InHigh = 1'b0;
    bus1.SC_PSRCtrl_SetCC_InHigh = 1'b0;
    bus1.SC_PSRCtrl_IsBranch_InHigh = 1'b0;
    bus1.SC_PSRCtrl_Cond_In = 4'h0;
    {bus1.SC_PSRCtrl_N_InHigh, bus1.SC_PSRCtrl_Z_InHigh,
     bus1.SC_PSRCtrl_V_InHigh, bus1.SC_PSRCtrl_C_InHigh} = 4'h0;

    #2;
    check1("rst_ready", int'(bus.SC_PSRCtrl_Ready_OutHigh), 1);
    check1("rst_oplatch", int'(bus.SC_PSRCtrl_OpLatch_OutHigh), 0);
    check1("rst_psrwrite", int'(bus.SC_PSRCtrl_PSRWrite_OutHigh), 0);
    check1("rst_done", int'(bus.SC_PSRCtrl_Done_OutHigh), 0);
    check1("rst_taken", int'(bus.SC_PSRCtrl_Taken_OutHigh), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // ALU_LAT=1 instance: always-taken branch, then a flag-setting op.
    dut1_op(1'b0, 4'd8, 4'h0);
    dut1_op(1'b1, 4'd1, 4'b0100);

    // Flag-setting compare then branch-on-equal, Z written as 1 then 0.
    run_op(1'b1, 1'b1, 4'd1, 4'b0100, 0, 1'b0, 1'b0);
    run_op(1'b1, 1'b1, 4'd1, 4'b0000, 0, 1'b0, 1'b0);

    // Full Bicc table, branch and non-branch.
    for (int br = 1; br >= 0; br--)
      for (int cd = 0; cd < 16; cd++)
        for (int fl = 0; fl < 16; fl++)
          run_op(1'($urandom), 1'(br), 4'(cd), 4'(fl), 0, 1'b0, 1'b0);

    // Flush in the WRPSR cycle, then in every other busy position.
    run_op(1'b1, 1'b1, 4'd8, 4'hF, LAT + 2, 1'b0, 1'b0);
    for (int r = 1; r <= LAT + 3; r++)
      run_op(1'b1, 1'b1, 4'd8, 4'h0, r, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 4'd8, 4'h0, LAT + 2, 1'b0, 1'b0);
    // Flush alongside an idle-state request: request still accepted.
    run_op(1'b0, 1'b1, 4'd8, 4'h0, 0, 1'b1, 1'b0);

    // Request held high continuously: back-to-back accepts.
    for (int i = 0; i < 40; i++)
      run_op(1'($urandom), 1'b1, 4'($urandom), 4'($urandom), 0, 1'b0, 1'b1);
    bus.SC_PSRCtrl_Req_InHigh = 1'b0;

    // Random mix with occasional flushes.
    for (int i = 0; i < 200; i++) begin
      bit sc;
      int fr;
      sc = 1'($urandom);
      fr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, LAT + 2 + int'(sc)) : 0;
      run_op(sc, ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), fr,
             ($urandom_range(0, 7) == 0), 1'($urandom));
    end
    bus.SC_PSRCtrl_Req_InHigh = 1'b0;

    // Asynchronous reset in the middle of EXEC.
    @(posedge clk); #1;
    exp_q.push_back('{EV_OPL, cyc + 1, 1'b0});
    win_start = cyc + 1;
    win_end   = cyc + 100;
    bus.SC_PSRCtrl_Req_InHigh      = 1'b1;
    bus.SC_PSRCtrl_SetCC_InHigh    = 1'b1;
    bus.SC_PSRCtrl_IsBranch_InHigh = 1'b1;
    bus.SC_PSRCtrl_Cond_In         = 4'd8;
    @(posedge clk); #1;
    bus.SC_PSRCtrl_Req_InHigh = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    win_start = 0;
    win_end   = 0;
    #1;
    check1("async_rst_ready", int'(bus.SC_PSRCtrl_Ready_OutHigh), 1);
    check1("async_rst_oplatch", int'(bus.SC_PSRCtrl_OpLatch_OutHigh), 0);
    check1("async_rst_psrwrite", int'(bus.SC_PSRCtrl_PSRWrite_OutHigh), 0);
    check1("async_rst_done", int'(bus.SC_PSRCtrl_Done_OutHigh), 0);
    check1("async_rst_taken", int'(bus.SC_PSRCtrl_Taken_OutHigh), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, 1'b1, 4'd9, 4'b0000, 0, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 4'd14, 4'b1000, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    check1("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
